neuron_mac: RTL

- Pre-activation stage of one neuron; sits directly upstream of the sigmoid activation.
- Accepts a stream of N_INPUTS signed 8-bit (activation, weight) pairs and multiply-accumulates them onto a bias.
- Rescales, rounds and saturates the sum to the signed 8-bit pre-activation that the sigmoid consumes.
- Result is held under a valid/ready handshake until the downstream stage takes it.

---
 rtl/nn_pkg.sv | 32 +++
 rtl/mac_round_sat.sv | 22 ++
 rtl/neuron_mac.sv | 113 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer stages: operand widths,
// the MAC sequencing states and the common round/shift/saturate helper.
package nn_pkg;

    localparam int ACT_W     = 8;
    localparam int WGT_W     = 8;
    localparam int BIAS_W    = 16;
    localparam int PROD_W    = ACT_W + WGT_W;
    localparam int SAT_ACC_W = 64;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        SCALE = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

    // Returns {sat, value[7:0]}. The rounding is half toward +inf because the
    // half-LSB is added before the arithmetic (floor) shift.
    function automatic logic [8:0] sat_round(input logic signed [SAT_ACC_W-1:0] acc,
                                             input int unsigned shift);
        logic signed [SAT_ACC_W-1:0] r;
        r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        if (r > 64'sd127) begin
            return {1'b1, 8'h7f};
        end else if (r < -64'sd128) begin
            return {1'b1, 8'h80};
        end else begin
            return {1'b0, r[7:0]};
        end
    endfunction

endpackage

// File: rtl/mac_round_sat.sv
// Combinational rescale of the accumulator to the signed 8-bit sigmoid input:
// round, arithmetic shift right by SHIFT, then clip to [-128, 127].
module mac_round_sat
    import nn_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [ACT_W-1:0] value,
    output logic                    sat
);

    logic signed [SAT_ACC_W-1:0] acc_ext;
    logic        [8:0]           rs;

    assign acc_ext = SAT_ACC_W'(acc);
    assign rs      = sat_round(acc_ext, 32'(SHIFT));
    assign sat     = rs[8];
    assign value   = rs[7:0];

endmodule

// File: rtl/neuron_mac.sv
// Pre-activation stage of one neuron: multiply-accumulates N_INPUTS (x, w)
// pairs onto a bias, then rescales/saturates and holds the result for the sigmoid.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 24,
    parameter int SHIFT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ACT_W-1:0]  x_in,
    input  logic signed [WGT_W-1:0]  w_in,
    input  logic signed [BIAS_W-1:0] bias_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACT_W-1:0]  pre_act,
    output logic                     sat
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

    generate
        if (N_INPUTS < 1 || N_INPUTS > 128) begin : g_bad_n_inputs
            $error("neuron_mac: N_INPUTS must be in 1..128");
        end
        if (SHIFT < 1 || SHIFT > 15) begin : g_bad_shift
            $error("neuron_mac: SHIFT must be in 1..15");
        end
        // Sized so the worst-case sum of N_INPUTS products plus bias cannot wrap.
        if (ACC_W < 17 + $clog2(N_INPUTS) || ACC_W > SAT_ACC_W) begin : g_bad_acc_w
            $error("neuron_mac: ACC_W too small for N_INPUTS (or wider than 64)");
        end
    endgenerate

    mac_state_t               state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACT_W-1:0]  pre_act_reg;
    logic                     sat_reg;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic        [ACT_W-1:0]  rnd_value;
    logic                     rnd_sat;

    assign prod     = x_in * w_in;
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(bias_in);

    mac_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc   (acc_reg),
        .value (rnd_value),
        .sat   (rnd_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ACC;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            pre_act_reg <= '0;
            sat_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (in_valid) begin
                        if (cnt_reg == '0) begin
                            acc_reg <= bias_ext + prod_ext;
                        end else begin
                            acc_reg <= acc_reg + prod_ext;
                        end
                        // With N_INPUTS = 1 beat 0 is also the last beat.
                        if (cnt_reg == LAST_BEAT) begin
                            cnt_reg   <= '0;
                            state_reg <= SCALE;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                SCALE: begin
                    pre_act_reg <= rnd_value;
                    sat_reg     <= rnd_sat;
                    state_reg   <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg <= ACC;
                    end
                end
                default: begin
                    state_reg <= ACC;
                end
            endcase
        end
    end

    // Handshake flags decode straight from the state register, so neither
    // ready depends combinationally on the other side of the block.
    assign in_ready  = (state_reg == ACC);
    assign out_valid = (state_reg == HOLD);
    assign pre_act   = pre_act_reg;
    assign sat       = sat_reg;

endmodule
